// File: rtl/i2c_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_ctrl
// Purpose  : Byte-level I2C master engine. Executes START, WRITE-byte,
//            READ-byte and STOP commands, one quarter bit period per tick.
//            SCL/SDA are open-drain controls toward the pad wrapper.
// Ports    : clk, rst_n (sync, active-low)
//            tick          - one-clk pulse per quarter bit period
//            cmd_valid/cmd - command request (0 START, 1 WRITE, 2 READ,
//                            3 STOP), accepted when cmd_valid && cmd_ready
//            wdata, ack_in - WRITE byte (MSB first) / READ ack choice
//            cmd_ready, busy, done - handshake and status
//            rdata, ack_out - last READ byte / last WRITE ack sample
//            scl_o (1 = released), sda_oe (1 = pull low), sda_i (pad level)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_byte_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  input  logic       ack_in,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_out,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam logic [1:0] c_CMD_START = 2'd0;
  localparam logic [1:0] c_CMD_WRITE = 2'd1;
  localparam logic [1:0] c_CMD_READ  = 2'd2;
  localparam logic [1:0] c_CMD_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BIT   = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [1:0] r_q,       w_q_nxt;
  logic [3:0] r_bit,     w_bit_nxt;
  logic [1:0] r_cmd,     w_cmd_nxt;
  logic [7:0] r_wdata,   w_wdata_nxt;
  logic       r_ack_in,  w_ack_in_nxt;
  logic [7:0] r_shift,   w_shift_nxt;
  logic [7:0] r_rdata,   w_rdata_nxt;
  logic       r_ack_out, w_ack_out_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_done,    w_done_nxt;
  logic       r_scl,     w_scl_nxt;
  logic       r_sda_oe,  w_sda_oe_nxt;
  logic       w_move;
  logic       w_last;

  // Bus levels {scl, sda_oe} for a given position inside a command.
  function automatic logic [1:0] f_levels(
    input state_t     st,
    input logic [1:0] q,
    input logic [3:0] bitn,
    input logic [1:0] c,
    input logic [7:0] wd,
    input logic       ak
  );
    logic scl;
    logic oe;
    scl = 1'b1;
    oe  = 1'b0;
    case (st)
      S_START: begin
        scl = (q != 2'd3);
        oe  = (q != 2'd0);
      end
      S_STOP: begin
        scl = (q != 2'd0);
        oe  = ~q[1];
      end
      S_BIT: begin
        scl = (q == 2'd1) || (q == 2'd2);
        if (bitn == 4'd8)
          oe = (c == c_CMD_READ) ? ak : 1'b0;   // ack slot
        else if (c == c_CMD_WRITE)
          oe = ~wd[3'd7 - bitn[2:0]];
        else
          oe = 1'b0;
      end
      default: begin
        scl = 1'b1;
        oe  = 1'b0;
      end
    endcase
    return {scl, oe};
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_bit_nxt     = r_bit;
    w_cmd_nxt     = r_cmd;
    w_wdata_nxt   = r_wdata;
    w_ack_in_nxt  = r_ack_in;
    w_shift_nxt   = r_shift;
    w_rdata_nxt   = r_rdata;
    w_ack_out_nxt = r_ack_out;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_scl_nxt     = r_scl;
    w_sda_oe_nxt  = r_sda_oe;
    w_move        = 1'b0;
    w_last        = (r_state != S_BIT) || (r_bit == 4'd8);

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_cmd_nxt    = cmd;
          w_wdata_nxt  = wdata;
          w_ack_in_nxt = ack_in;
          w_q_nxt      = 2'd0;
          w_bit_nxt    = 4'd0;
          w_busy_nxt   = 1'b1;
          w_move       = 1'b1;
          case (cmd)
            c_CMD_START: w_state_nxt = S_START;
            c_CMD_STOP:  w_state_nxt = S_STOP;
            default:     w_state_nxt = S_BIT;
          endcase
        end
      end
      default: begin
        if (tick) begin
          // SDA is sampled on the tick closing the SCL-high window.
          if (r_state == S_BIT && r_q == 2'd2) begin
            if (r_bit == 4'd8) begin
              if (r_cmd == c_CMD_WRITE)
                w_ack_out_nxt = sda_i;
            end else if (r_cmd == c_CMD_READ) begin
              w_shift_nxt = {r_shift[6:0], sda_i};
            end
          end
          if (r_q == 2'd3) begin
            if (w_last) begin
              // Bus levels are left as they are: IDLE holds the last quarter.
              w_state_nxt = S_IDLE;
              w_q_nxt     = 2'd0;
              w_bit_nxt   = 4'd0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              if (r_cmd == c_CMD_READ)
                w_rdata_nxt = r_shift;
            end else begin
              w_q_nxt   = 2'd0;
              w_bit_nxt = r_bit + 4'd1;
              w_move    = 1'b1;
            end
          end else begin
            w_q_nxt = r_q + 2'd1;
            w_move  = 1'b1;
          end
        end
      end
    endcase

    // Levels are registered from the position being entered, so they change
    // only on the edge that starts a new quarter.
    if (w_move)
      {w_scl_nxt, w_sda_oe_nxt} = f_levels(w_state_nxt, w_q_nxt, w_bit_nxt,
                                           w_cmd_nxt, w_wdata_nxt, w_ack_in_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_cmd     <= c_CMD_START;
      r_wdata   <= 8'h00;
      r_ack_in  <= 1'b0;
      r_shift   <= 8'h00;
      r_rdata   <= 8'h00;
      r_ack_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_oe  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_q       <= w_q_nxt;
      r_bit     <= w_bit_nxt;
      r_cmd     <= w_cmd_nxt;
      r_wdata   <= w_wdata_nxt;
      r_ack_in  <= w_ack_in_nxt;
      r_shift   <= w_shift_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ack_out <= w_ack_out_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_scl     <= w_scl_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign ack_out   = r_ack_out;
  assign scl_o     = r_scl;
  assign sda_oe    = r_sda_oe;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_byte_ctrl
// Purpose  : Self-checking bench for i2c_byte_ctrl. Expected read data and
//            ack status are queued at command issue and compared on done;
//            bus levels are compared every quarter against a spec table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_ctrl;

  localparam logic [1:0] c_START = 2'd0;
  localparam logic [1:0] c_WRITE = 2'd1;
  localparam logic [1:0] c_READ  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tick      = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd       = 2'd0;
  logic [7:0] wdata     = 8'h00;
  logic       ack_in    = 1'b0;
  logic       sda_i     = 1'b1;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_out;
  logic       scl_o;
  logic       sda_oe;

  i2c_byte_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .wdata     (wdata),
    .ack_in    (ack_in),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .ack_out   (ack_out),
    .scl_o     (scl_o),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       ack;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] model_rdata = 8'h00;
  logic       model_ack   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {scl, sda_oe} for quarter index idx of a command.
  function automatic logic [1:0] exp_lvl(input logic [1:0] c, input logic [7:0] wd,
                                         input logic ak, input int idx);
    int   b;
    int   q;
    logic scl;
    logic oe;
    b = idx / 4;
    q = idx % 4;
    case (c)
      c_START: begin scl = (q != 3); oe = (q != 0); end
      c_STOP:  begin scl = (q != 0); oe = (q < 2);  end
      default: begin
        scl = (q == 1) || (q == 2);
        if (b == 8)       oe = (c == c_READ) ? ak : 1'b0;
        else if (c == c_WRITE) oe = ~wd[7 - b];
        else              oe = 1'b0;
      end
    endcase
    return {scl, oe};
  endfunction

  // Scoreboard side: every done pulse must match exactly one queued command.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check_eq("done_pending", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("sb_rdata", rdata, mon_e.rdata);
        check_eq("sb_ack_out", ack_out, mon_e.ack);
      end
    end
  end

  task automatic check_reset(input string nm);
    check_eq({nm, "_scl"},   scl_o,     1);
    check_eq({nm, "_sda"},   sda_oe,    0);
    check_eq({nm, "_busy"},  busy,      0);
    check_eq({nm, "_ready"}, cmd_ready, 1);
    check_eq({nm, "_done"},  done,      0);
    check_eq({nm, "_rdata"}, rdata,     8'h00);
    check_eq({nm, "_ack"},   ack_out,   0);
  endtask

  // slv[8-n] is what the slave puts on SDA during bit n.
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic ak,
                         input logic [8:0] slv, input int gap, input int poke_at,
                         input int abort_at, input string nm);
    int         nt;
    int         pos;
    logic [7:0] rd_old;
    exp_t       e;
    nt     = (c == c_WRITE || c == c_READ) ? 36 : 4;
    rd_old = model_rdata;
    if (abort_at < 0) begin
      e.rdata = (c == c_READ)  ? slv[8:1] : model_rdata;
      e.ack   = (c == c_WRITE) ? slv[0]   : model_ack;
      sb.push_back(e);
      model_rdata = e.rdata;
      model_ack   = e.ack;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = wd; ack_in = ak; sda_i = slv[8];
    @(posedge clk); #1;
    cmd_valid = 1'b0; wdata = ~wd; ack_in = ~ak;   // inputs must be latched
    check_eq({nm, "_acc_busy"},  busy, 1);
    check_eq({nm, "_acc_ready"}, cmd_ready, 0);
    check_eq({nm, "_acc_lvl"},   {scl_o, sda_oe}, exp_lvl(c, wd, ak, 0));
    for (int k = 0; k < nt; k++) begin
      repeat (gap - 1) @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("%s_hold%0d", nm, k), {scl_o, sda_oe}, exp_lvl(c, wd, ak, k));
      if (k == poke_at) begin cmd_valid = 1'b1; cmd = c_STOP; end
      if (k == abort_at) rst_n = 1'b0;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0; cmd_valid = 1'b0;
      if (k == abort_at) begin
        check_reset({nm, "_rst"});
        rst_n = 1'b1;
        model_rdata = 8'h00;
        model_ack   = 1'b0;
        return;
      end
      pos = k + 1;
      if (pos < nt) begin
        if (nt == 36) sda_i = slv[8 - pos / 4];
        check_eq($sformatf("%s_lvl%0d", nm, pos), {scl_o, sda_oe}, exp_lvl(c, wd, ak, pos));
        check_eq($sformatf("%s_nodone%0d", nm, pos), done, 0);
        if (c == c_READ)
          check_eq($sformatf("%s_rd_hold%0d", nm, pos), rdata, rd_old);
      end else begin
        check_eq({nm, "_done"},    done, 1);
        check_eq({nm, "_busy0"},   busy, 0);
        check_eq({nm, "_ready1"},  cmd_ready, 1);
        check_eq({nm, "_endlvl"},  {scl_o, sda_oe}, exp_lvl(c, wd, ak, nt - 1));
        check_eq({nm, "_rdata"},   rdata, model_rdata);
        check_eq({nm, "_ack_out"}, ack_out, model_ack);
        @(posedge clk); #1;
        check_eq({nm, "_done_1cyc"}, done, 0);
        check_eq({nm, "_idle_lvl"},  {scl_o, sda_oe}, exp_lvl(c, wd, ak, nt - 1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    // Ticks while idle must not disturb anything.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tick = 1'b1;
      @(posedge clk); #1; tick = 1'b0;
    end
    check_reset("idle_tick");

    run_cmd(c_START, 8'h00, 1'b0, 9'h1FF, 10, -1, -1, "start");
    run_cmd(c_STOP,  8'h00, 1'b0, 9'h1FF, 10, -1, -1, "stop");
    run_cmd(c_START, 8'h00, 1'b0, 9'h1FF, 3,  -1, -1, "start2");
    run_cmd(c_WRITE, 8'hA5, 1'b0, 9'h1FE, 3,  -1, -1, "wr_a5");
    run_cmd(c_WRITE, 8'hFF, 1'b0, 9'h1FF, 1,  -1, -1, "wr_ff");
    run_cmd(c_READ,  8'h00, 1'b0, {8'h3C, 1'b1}, 2, -1, -1, "rd_3c");
    run_cmd(c_WRITE, 8'h5A, 1'b0, 9'h000, 2,  10, -1, "wr_poke");
    run_cmd(c_READ,  8'h00, 1'b0, {8'hC3, 1'b0}, 2, -1, 20, "rd_abort");
    repeat (5) @(posedge clk);
    run_cmd(c_READ,  8'h00, 1'b1, {8'h81, 1'b1}, 1, -1, -1, "rd_81");
    run_cmd(c_STOP,  8'h00, 1'b0, 9'h1FF, 1,  -1, -1, "stop2");
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
